hams_merge2stream: RTL

- Streaming 2-way merge unit: consumes two already-sorted runs of `pair` elements (A and B) and emits one merged sorted run.
- It is the downstream consumer of the compare-exchange sorting network. Sorted runs produced there are merged here into longer runs in the HAMS merge tree.
- Ordering key is `pair.info`. Direction (ascending or descending) is selectable per run.
- Stable: on equal keys, A wins.

---
 rtl/hams_merge2stream.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hams_merge2stream.sv
// hams_merge2stream: streaming 2-way merge of two sorted runs of pair elements.
// Stable (A wins ties), direction latched per run, one registered output stage.

package hams_pkg;
    // Element moved through the HAMS merge tree. Only info is used as the sort key;
    // tag is carried along untouched (payload / origin identifier).
    typedef struct packed {
        logic [15:0] info;
        logic [15:0] tag;
    } pair;
endpackage

module hams_merge2stream
    import hams_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   direction,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [$bits(pair)-1:0] a_data,
    input  logic                   a_last,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [$bits(pair)-1:0] b_data,
    input  logic                   b_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$bits(pair)-1:0] out_data,
    output logic                   out_last,
    output logic                   run_done,
    output logic [CNT_W-1:0]       out_count
);

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        DRAIN_A,
        DRAIN_B,
        DONE
    } state_t;

    state_t state, state_d;
    logic   dir_q;
    pair    a_pair, b_pair;
    logic   adv;
    logic   sel_a;
    logic   accept_a, accept_b;
    logic   load_last;

    assign a_pair = a_data;
    assign b_pair = b_data;

    // Output register can take a new element when empty or being drained this cycle.
    assign adv = !out_valid || out_ready;

    // Head selection: unsigned compare on info, ties resolved towards A for stability.
    assign sel_a = dir_q ? (a_pair.info <= b_pair.info) : (a_pair.info >= b_pair.info);

    assign accept_a = a_valid && a_ready;
    assign accept_b = b_valid && b_ready;

    // Next-state and ready generation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d   = state;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        load_last = 1'b0;
        run_done  = 1'b0;
        case (state)
            IDLE: begin
                if (a_valid && b_valid) state_d = MERGE;
            end
            MERGE: begin
                // Both heads are needed before a decision can be made.
                if (a_valid && b_valid) begin
                    if (sel_a) begin
                        a_ready = adv;
                        if (adv && a_last) state_d = DRAIN_B;
                    end else begin
                        b_ready = adv;
                        if (adv && b_last) state_d = DRAIN_A;
                    end
                end
            end
            DRAIN_A: begin
                a_ready = adv;
                if (accept_a && a_last) begin
                    load_last = 1'b1;
                    state_d   = DONE;
                end
            end
            DRAIN_B: begin
                b_ready = adv;
                if (accept_b && b_last) begin
                    load_last = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready && out_last) begin
                    run_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and per-run direction capture.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
            dir_q <= 1'b1;
        end else begin
            state <= state_d;
            if (state == IDLE && a_valid && b_valid) dir_q <= direction;
        end
    end

    // Single output stage: loads on every input acceptance, empties when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept_a || accept_b) begin
            out_valid <= 1'b1;
            out_data  <= accept_a ? a_data : b_data;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Count of elements accepted downstream in the current run, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_count <= '0;
        end else if (run_done) begin
            out_count <= '0;
        end else if (out_valid && out_ready && (out_count != {CNT_W{1'b1}})) begin
            out_count <= out_count + 1'b1;
        end
    end

endmodule
